// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the processor and
//   NUM_REQ peripheral counters. The processor always wins. Peripheral
//   increments accumulate in small saturating counters. They are injected as
//   absolute register writes (shadow + pending) on cycles where the processor
//   does not write. Requester i owns register BASE_REG-i. BASE_REG-NUM_REQ+1
//   must be >= 1 and BASE_REG must be <= 31.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   cpu_we/cpu_rd/cpu_data processor write port (input side)
//   req_valid/req_inc     per-requester increment strobe and amount
//   rf_we/rf_rd/rf_data   regfile write port (output side, combinational mux)
//   grant                 one-hot, requester injected this cycle
//   shadow                committed value of each owned register (32b each)
//   overflow              sticky, a pending accumulator clipped at saturation
module regfile_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int BASE_REG = 30,
    parameter int INC_W    = 3,
    parameter int PEND_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic [4:0]               cpu_rd,
    input  logic [31:0]              cpu_data,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*INC_W-1:0] req_inc,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [31:0]              rf_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ*32-1:0]    shadow,
    output logic [NUM_REQ-1:0]       overflow
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so the pre-saturation sum never wraps.
    localparam int SUM_W = ((PEND_W > INC_W) ? PEND_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

    logic [31:0]       shadow_q [NUM_REQ];
    logic [31:0]       shadow_d [NUM_REQ];
    logic [PEND_W-1:0] pend_q   [NUM_REQ];
    logic [PEND_W-1:0] pend_d   [NUM_REQ];
    logic [SUM_W-1:0]  sum_c    [NUM_REQ];
    logic [NUM_REQ-1:0] ovf_q, ovf_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic [NUM_REQ-1:0] grant_vec;
    int                cand;

    // Round-robin search over nonzero accumulators, starting at the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && pend_q[cand] != '0) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    // Write-port mux: processor first, then the arbitration winner.
    always_comb begin
        rf_we     = 1'b0;
        rf_rd     = '0;
        rf_data   = '0;
        grant_vec = '0;
        if (cpu_we) begin
            rf_we   = 1'b1;
            rf_rd   = cpu_rd;
            rf_data = cpu_data;
        end else if (win_found) begin
            rf_we     = 1'b1;
            rf_rd     = 5'(BASE_REG - int'(win_idx));
            rf_data   = shadow_q[win_idx] + 32'(pend_q[win_idx]);
            grant_vec = NUM_REQ'(1) << win_idx;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            shadow_d[i] = shadow_q[i];
            if (grant_vec[i])
                shadow_d[i] = shadow_q[i] + 32'(pend_q[i]);
            else if (cpu_we && cpu_rd == 5'(BASE_REG - i))
                shadow_d[i] = cpu_data;

            // A grant drains the accumulator, but an increment landing in the
            // same cycle is kept for the next injection.
            sum_c[i] = (grant_vec[i] ? '0 : SUM_W'(pend_q[i]))
                     + (req_valid[i] ? SUM_W'(req_inc[i*INC_W +: INC_W]) : '0);
            if (sum_c[i] > PEND_MAX) begin
                pend_d[i] = PEND_MAX[PEND_W-1:0];
                ovf_d[i]  = 1'b1;
            end else begin
                pend_d[i] = sum_c[i][PEND_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vec != '0)
            ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '{default: '0};
            pend_q   <= '{default: '0};
            ovf_q    <= '0;
            ptr_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        shadow = '0;
        for (int i = 0; i < NUM_REQ; i++) shadow[i*32 +: 32] = shadow_q[i];
    end

    assign grant    = grant_vec;
    assign overflow = ovf_q;

endmodule
